// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: credit-limited imem requests, tagged fetch queue, redirect flush
// Optional build macro FETCH_PERF_CNT_EN adds stall_cycles/flush_count outputs.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 24,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              stall,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  output logic [PC_W-1:0]   PC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INST_W-1:0] data_q [DEPTH];
  logic [PC_W-1:0]   dpc_q  [DEPTH];
  logic [PC_W-1:0]   tag_q  [DEPTH];

  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0]   tag_rd_q, tag_wr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW:0] in_flight;
  logic        accept, push, pop, drop;

  // Queued plus in-flight entries never exceed DEPTH, so a push always finds room.
  assign in_flight      = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = !rst && !redirect_valid && (in_flight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign PC             = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign inst_valid = !rst && (count_q != '0);
  assign inst       = inst_valid ? data_q[rd_q] : '0;
  assign inst_pc    = inst_valid ? dpc_q[rd_q] : '0;

  assign drop = redirect_valid || (discard_q != '0);
  assign push = imem_rsp_valid && !drop;
  assign pop  = inst_valid && !stall && !redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    if (accept) pc_d = pc_q + PC_W'(1);
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the squashed path.
      pc_d      = redirect_pc;
      discard_d = outstanding_d;
      rd_d      = '0;
      wr_d      = '0;
      count_d   = '0;
    end else begin
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rd_q          <= '0;
      wr_q          <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      tag_rd_q      <= tag_rd_q + AW'(imem_rsp_valid);
      tag_wr_q      <= tag_wr_q + AW'(accept);
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Tag queue tracks every issued address, squashed or not, so it stays aligned with responses.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr_q] <= pc_q;
    if (push) begin
      data_q[wr_q] <= imem_rsp_data;
      dpc_q[wr_q]  <= tag_q[tag_rd_q];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (inst_valid && stall && (stall_cycles_q != 16'hFFFF))
        stall_cycles_q <= stall_cycles_q + 16'd1;
      if (redirect_valid && (flush_count_q != 16'hFFFF))
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - bench for fetch_stage: directed phase table plus randomized traffic vs queue model
// Checks perf counters when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [23:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic [23:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic [15:0] PC;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  fetch_stage #(.PC_W(16), .INST_W(24), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .PC(PC)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; int due; } mreq_t;
  typedef struct { logic [15:0] pc; logic [23:0] data; } ent_t;
  typedef struct { logic [15:0] addr; bit drop; } tag_t;
  typedef struct {
    bit rst; bit ready; int lat; bit stall; bit redir; logic [15:0] rpc; int n;
    bit ev; logic [15:0] eipc; bit ereq; logic [15:0] epc;
  } phase_t;

  mreq_t mq[$];
  ent_t  fq[$];
  tag_t  oq[$];
  logic [15:0] mpc = 16'h0000;
  logic [15:0] exp_sc = 16'h0000, exp_fc = 16'h0000;
  bit    exp_iv, exp_req;
  int    cyc = 0, lat = 1;
  bit    rsp_en = 1'b1;
  int    n_vec = 0, n_bad = 0;
  phase_t tbl[21];

  function automatic logic [23:0] mdata(input logic [15:0] a);
    return {a[15:8] + a[7:0] + 8'h3C, a ^ 16'h5A3C};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive memory response, compare outputs to the model, then advance memory and model.
  task automatic cycle();
    bit acc, rsp;
    logic [15:0] acc_addr;
    tag_t t;
    imem_rsp_valid = !rst && rsp_en && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? mdata(mq[0].addr) : 24'h0;
    #2;
    exp_iv  = !rst && (fq.size() > 0);
    exp_req = !rst && !redirect_valid && (fq.size() + oq.size() < DEPTH);
    chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
    chk("inst", 32'(inst), exp_iv ? 32'(fq[0].data) : 32'h0);
    chk("inst_pc", 32'(inst_pc), exp_iv ? 32'(fq[0].pc) : 32'h0);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (!rst) chk("PC", 32'(PC), 32'(mpc));
    if (exp_req) chk("req_addr", 32'(imem_req_addr), 32'(mpc));
`ifdef FETCH_PERF_CNT_EN
    if (!rst) begin
      chk("stall_cycles", 32'(stall_cycles), 32'(exp_sc));
      chk("flush_count", 32'(flush_count), 32'(exp_fc));
    end
`endif
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    rsp      = imem_rsp_valid;
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (rsp) void'(mq.pop_front());
      if (acc) mq.push_back('{acc_addr, cyc + lat});
    end
    if (rst) begin
      fq.delete(); oq.delete(); mpc = 16'h0000; exp_sc = 16'h0; exp_fc = 16'h0;
    end else begin
      if (exp_iv && stall && exp_sc != 16'hFFFF) exp_sc++;
      if (redirect_valid && exp_fc != 16'hFFFF) exp_fc++;
      if (redirect_valid) begin
        fq.delete();
        if (rsp && oq.size() > 0) void'(oq.pop_front());
        foreach (oq[i]) oq[i].drop = 1'b1;
        mpc = redirect_pc;
      end else begin
        if (exp_iv && !stall) void'(fq.pop_front());
        if (rsp && oq.size() > 0) begin
          t = oq.pop_front();
          if (!t.drop) fq.push_back('{t.addr, mdata(t.addr)});
        end
        if (exp_req && imem_req_ready) begin
          oq.push_back('{mpc, 1'b0});
          mpc = mpc + 16'd1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    //            rst rdy lat st rd rpc       n   ev eipc      req pc
    tbl[0]  = '{1, 1, 1, 0, 0, 16'h0000, 2,  0, 16'h0000, 0, 16'h0000};
    tbl[1]  = '{0, 1, 1, 0, 0, 16'h0000, 2,  1, 16'h0000, 1, 16'h0002};
    tbl[2]  = '{0, 1, 1, 0, 0, 16'h0000, 1,  1, 16'h0001, 1, 16'h0003};
    tbl[3]  = '{1, 1, 1, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0000};
    tbl[4]  = '{0, 1, 1, 1, 0, 16'h0000, 10, 1, 16'h0000, 0, 16'h0004};
    tbl[5]  = '{0, 1, 1, 0, 0, 16'h0000, 1,  1, 16'h0001, 1, 16'h0004};
    tbl[6]  = '{0, 1, 1, 0, 0, 16'h0000, 3,  1, 16'h0004, 1, 16'h0007};
    tbl[7]  = '{1, 1, 3, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0000};
    tbl[8]  = '{0, 1, 3, 0, 0, 16'h0000, 2,  0, 16'h0000, 1, 16'h0002};
    tbl[9]  = '{0, 1, 3, 0, 1, 16'h0040, 1,  0, 16'h0000, 0, 16'h0040};
    tbl[10] = '{0, 1, 3, 0, 0, 16'h0000, 4,  1, 16'h0040, 0, 16'h0044};
    tbl[11] = '{1, 1, 1, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0000};
    tbl[12] = '{0, 1, 1, 0, 0, 16'h0000, 2,  1, 16'h0000, 1, 16'h0002};
    tbl[13] = '{0, 1, 1, 0, 1, 16'h0100, 1,  0, 16'h0000, 0, 16'h0100};
    tbl[14] = '{0, 1, 1, 0, 0, 16'h0000, 2,  1, 16'h0100, 1, 16'h0102};
    tbl[15] = '{1, 1, 1, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0000};
    tbl[16] = '{0, 1, 1, 0, 1, 16'hFFFE, 1,  0, 16'h0000, 0, 16'hFFFE};
    tbl[17] = '{0, 1, 1, 0, 0, 16'h0000, 2,  1, 16'hFFFE, 1, 16'h0000};
    tbl[18] = '{0, 1, 1, 0, 0, 16'h0000, 1,  1, 16'hFFFF, 1, 16'h0001};
    tbl[19] = '{0, 1, 1, 0, 0, 16'h0000, 1,  1, 16'h0000, 1, 16'h0002};
    tbl[20] = '{0, 1, 1, 0, 0, 16'h0000, 1,  1, 16'h0001, 1, 16'h0003};

    rst = 1'b1; imem_req_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 24'h0;
    @(posedge clk); #1;

    for (int p = 0; p < 21; p++) begin
      rst = tbl[p].rst; imem_req_ready = tbl[p].ready; lat = tbl[p].lat;
      stall = tbl[p].stall; redirect_valid = tbl[p].redir; redirect_pc = tbl[p].rpc;
      for (int k = 0; k < tbl[p].n; k++) cycle();
      #2;
      chk($sformatf("tbl%0d.inst_valid", p), 32'(inst_valid), 32'(tbl[p].ev));
      chk($sformatf("tbl%0d.inst_pc", p), 32'(inst_pc), 32'(tbl[p].eipc));
      chk($sformatf("tbl%0d.inst", p), 32'(inst), tbl[p].ev ? 32'(mdata(tbl[p].eipc)) : 32'h0);
      chk($sformatf("tbl%0d.req_valid", p), 32'(imem_req_valid), 32'(tbl[p].ereq));
      chk($sformatf("tbl%0d.PC", p), 32'(PC), 32'(tbl[p].epc));
    end

    redirect_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom % 150) == 0;
      imem_req_ready = ($urandom % 4) != 0;
      stall          = ($urandom % 3) == 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = (($urandom % 4) == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
      rsp_en         = ($urandom % 5) != 0;
      if (($urandom % 50) == 0) lat = 1 + int'($urandom % 4);
      cycle();
    end

`ifdef FETCH_PERF_CNT_EN
    rst = 1'b1; imem_req_ready = 1'b1; lat = 1; stall = 1'b0; redirect_valid = 1'b0; rsp_en = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    stall = 1'b1;
    repeat (5) cycle();
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0200;
    repeat (2) cycle();
    redirect_valid = 1'b0;
    #2;
    chk("perf.stall_cycles", 32'(stall_cycles), 32'd5);
    chk("perf.flush_count", 32'(flush_count), 32'd2);
    rst = 1'b1;
    cycle();
    chk("perf.stall_cycles_rst", 32'(stall_cycles), 32'd0);
    chk("perf.flush_count_rst", 32'(flush_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
